// File: rtl/riv_async_fifo_ptr_xfer_ctl_if.sv
// Pointer/handshake bundle for one side of the async FIFO pointer controller.
// The controller sits on the slave modport; the FIFO datapath or bench drives the master side.
interface riv_async_fifo_ptr_xfer_ctl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int INC_WIDTH  = 1
);
    logic                  en;
    logic [INC_WIDTH-1:0]  inc;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   ptr;
    logic [ADDR_WIDTH:0]   xfer_ptr;
    logic                  xfer_req;
    logic                  xfer_ack;
    logic                  busy;

    modport master (
        output en, inc, flush, xfer_ack,
        input  addr, ptr, xfer_ptr, xfer_req, busy
    );

    modport slave (
        input  en, inc, flush, xfer_ack,
        output addr, ptr, xfer_ptr, xfer_req, busy
    );
endinterface

// File: rtl/riv_async_fifo_ptr_xfer_ctl.sv
// One-side async FIFO pointer controller: wrap-bit pointer with arbitrary depth plus 4-phase snapshot transfer.
// Optional feature macro RIV_ASYNC_FIFO_PTR_GRAY_EN: Gray-code the published snapshot.
module riv_async_fifo_ptr_xfer_ctl #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int INC_WIDTH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    riv_async_fifo_ptr_xfer_ctl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_REQ      = 3'd4
    } state_t;

    localparam int SUM_W = ((INC_WIDTH > ADDR_WIDTH) ? INC_WIDTH : ADDR_WIDTH) + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  wrap_q, wrap_nxt;
    logic                  dirty_q, dirty_nxt;
    logic                  req_q, req_nxt;
    logic [ADDR_WIDTH:0]   xfer_ptr_q;
    logic [ADDR_WIDTH:0]   ptr_cur;
    logic [ADDR_WIDTH:0]   snap;
    logic [SUM_W-1:0]      sum;
    logic                  ack_s;

    assign ptr_cur = {wrap_q, addr_q};

`ifdef RIV_ASYNC_FIFO_PTR_GRAY_EN
    assign snap = ptr_cur ^ (ptr_cur >> 1);
`else
    assign snap = ptr_cur;
`endif

    // Wider sum keeps addr+inc exact so one subtraction of DEPTH folds any non-power-of-2 wrap.
    always_comb begin
        sum      = SUM_W'(addr_q) + SUM_W'(bus.inc);
        addr_nxt = addr_q;
        wrap_nxt = wrap_q;
        if (bus.flush) begin
            addr_nxt = '0;
            wrap_nxt = 1'b0;
        end else if (bus.en) begin
            if (sum >= DEPTH_S) begin
                addr_nxt = ADDR_WIDTH'(sum - DEPTH_S);
                wrap_nxt = ~wrap_q;
            end else begin
                addr_nxt = ADDR_WIDTH'(sum);
            end
        end
    end

    assign dirty_nxt = bus.flush
                     | (bus.en & (bus.inc != '0))
                     | (dirty_q & (state_q != ST_LOAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            addr_q  <= addr_nxt;
            wrap_q  <= wrap_nxt;
            dirty_q <= dirty_nxt;
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign ack_s = bus.xfer_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.xfer_ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign ack_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Unused encodings fall back to RESET and drop the request so the far side sees a clean low.
    always_comb begin
        state_nxt = state_q;
        req_nxt   = req_q;
        case (state_q)
            ST_RESET: begin
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (dirty_q) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!ack_s) begin
                    state_nxt = ST_REQ;
                    req_nxt   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = dirty_q ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_RESET;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            req_q      <= 1'b0;
            xfer_ptr_q <= '0;
        end else begin
            state_q <= state_nxt;
            req_q   <= req_nxt;
            if (state_q == ST_LOAD) begin
                xfer_ptr_q <= snap;
            end
        end
    end

    assign bus.addr     = addr_q;
    assign bus.ptr      = ptr_cur;
    assign bus.xfer_ptr = xfer_ptr_q;
    assign bus.xfer_req = req_q;
    assign bus.busy     = dirty_q | ((state_q != ST_IDLE) && (state_q != ST_RESET));

endmodule

// File: tb/tb_riv_async_fifo_ptr_xfer_ctl.sv
// Directed bench for the pointer/xfer controller: an 8-deep instance with 2-stage ack sync
// and a 6-deep instance for non-power-of-2 wrap; expected values are hand-derived cycle by cycle.
module tb_riv_async_fifo_ptr_xfer_ctl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    riv_async_fifo_ptr_xfer_ctl_if #(.ADDR_WIDTH(3), .INC_WIDTH(4)) bus8 ();
    riv_async_fifo_ptr_xfer_ctl_if #(.ADDR_WIDTH(3), .INC_WIDTH(3)) bus6 ();

    riv_async_fifo_ptr_xfer_ctl #(
        .DEPTH(8), .INC_WIDTH(4), .SYNC_STAGES(2)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    riv_async_fifo_ptr_xfer_ctl #(
        .DEPTH(6), .INC_WIDTH(3), .SYNC_STAGES(2)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected far-side snapshot encoding for a given binary pointer.
    function automatic logic [31:0] expXfer(input logic [31:0] p);
`ifdef RIV_ASYNC_FIFO_PTR_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel6, input logic e, input logic [3:0] i,
                                 input logic f, input logic a);
        if (sel6) begin
            bus6.en       = e;
            bus6.inc      = i[2:0];
            bus6.flush    = f;
            bus6.xfer_ack = a;
        end else begin
            bus8.en       = e;
            bus8.inc      = i;
            bus8.flush    = f;
            bus8.xfer_ack = a;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rst_addr",     32'(bus8.addr),     32'd0);
        checkOutput("rst_ptr",      32'(bus8.ptr),      32'd0);
        checkOutput("rst_xfer_ptr", 32'(bus8.xfer_ptr), 32'd0);
        checkOutput("rst_req",      32'(bus8.xfer_req), 32'd0);
        checkOutput("rst_busy",     32'(bus8.busy),     32'd0);
        checkOutput("rst_ptr6",     32'(bus6.ptr),      32'd0);

        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            checkOutput("idle_req",  32'(bus8.xfer_req), 32'd0);
            checkOutput("idle_busy", 32'(bus8.busy),     32'd0);
            checkOutput("idle_ptr",  32'(bus8.ptr),      32'd0);
        end

        $display("[TB] single increment latency");
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("lat_t1_ptr",  32'(bus8.ptr),      32'd1);
        checkOutput("lat_t1_busy", 32'(bus8.busy),     32'd1);
        checkOutput("lat_t1_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("lat_t2_xfer", 32'(bus8.xfer_ptr), 32'd0);
        checkOutput("lat_t2_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("lat_t3_xfer", 32'(bus8.xfer_ptr), expXfer(32'd1));
        checkOutput("lat_t3_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("lat_t4_req",  32'(bus8.xfer_req), 32'd1);
        tick();
        checkOutput("lat_t5_req",  32'(bus8.xfer_req), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        checkOutput("lat_t7_req",  32'(bus8.xfer_req), 32'd1);
        tick();
        checkOutput("lat_t8_req",  32'(bus8.xfer_req), 32'd1);
        tick();
        checkOutput("lat_t9_req",  32'(bus8.xfer_req), 32'd0);
        checkOutput("lat_t9_busy", 32'(bus8.busy),     32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] non-power-of-2 wrap on depth 6");
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        tick();
        checkOutput("d6_addr5", 32'(bus6.addr), 32'd5);
        checkOutput("d6_ptr5",  32'(bus6.ptr),  32'd5);
        applyStimulus(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        checkOutput("d6_wrap_addr", 32'(bus6.addr), 32'd1);
        checkOutput("d6_wrap_ptr",  32'(bus6.ptr),  32'h9);
        applyStimulus(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        checkOutput("d6_lap_addr", 32'(bus6.addr), 32'd1);
        checkOutput("d6_lap_ptr",  32'(bus6.ptr),  32'd1);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        checkOutput("d6_inc0_ptr", 32'(bus6.ptr),  32'd1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("[TB] updates while request outstanding");
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        checkOutput("hold_ptr2", 32'(bus8.ptr), 32'd2);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("hold_xfer2", 32'(bus8.xfer_ptr), expXfer(32'd2));
        tick();
        checkOutput("hold_req_up", 32'(bus8.xfer_req), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
            tick();
            checkOutput("hold_xfer_stable", 32'(bus8.xfer_ptr), expXfer(32'd2));
            checkOutput("hold_req_stable",  32'(bus8.xfer_req), 32'd1);
            checkOutput("hold_ptr_inc",     32'(bus8.ptr),      32'(3 + k));
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("hold_a2_req",  32'(bus8.xfer_req), 32'd1);
        tick();
        checkOutput("hold_a3_req",  32'(bus8.xfer_req), 32'd0);
        checkOutput("hold_a3_xfer", 32'(bus8.xfer_ptr), expXfer(32'd2));
        tick();
        checkOutput("hold_a4_xfer", 32'(bus8.xfer_ptr), expXfer(32'd6));
        checkOutput("hold_a4_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        tick();
        checkOutput("hold_a6_req",  32'(bus8.xfer_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checkOutput("hold_a7_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("hold_a8_req",  32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("hold_a9_req",  32'(bus8.xfer_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (3) tick();
        checkOutput("hold_done_req", 32'(bus8.xfer_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("hold_done_busy", 32'(bus8.busy), 32'd0);

        $display("[TB] flush during handshake");
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        checkOutput("fl_en_and_flush", 32'(bus8.ptr), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        tick();
        checkOutput("fl_ptr5", 32'(bus8.ptr), 32'd5);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checkOutput("fl_xfer5", 32'(bus8.xfer_ptr), expXfer(32'd5));
        tick();
        checkOutput("fl_req_up", 32'(bus8.xfer_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_in_req_ptr",  32'(bus8.ptr),      32'd0);
        checkOutput("fl_in_req_xfer", 32'(bus8.xfer_ptr), expXfer(32'd5));
        checkOutput("fl_in_req_req",  32'(bus8.xfer_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("fl_c3_req",  32'(bus8.xfer_req), 32'd0);
        checkOutput("fl_c3_xfer", 32'(bus8.xfer_ptr), expXfer(32'd5));
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checkOutput("fl_c4_xfer0", 32'(bus8.xfer_ptr), 32'd0);
        checkOutput("fl_c4_req",   32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("fl_c5_req",   32'(bus8.xfer_req), 32'd0);
        tick();
        checkOutput("fl_c6_req",   32'(bus8.xfer_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (3) tick();
        checkOutput("fl_done_req", 32'(bus8.xfer_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("fl_done_busy", 32'(bus8.busy), 32'd0);

        $display("[TB] snapshot encoding, full-lap increment, async reset");
        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        checkOutput("enc_ptr6", 32'(bus8.ptr), 32'h6);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
`ifdef RIV_ASYNC_FIFO_PTR_GRAY_EN
        checkOutput("enc_xfer", 32'(bus8.xfer_ptr), 32'h5);
`else
        checkOutput("enc_xfer", 32'(bus8.xfer_ptr), 32'h6);
`endif
        tick();
        checkOutput("enc_req", 32'(bus8.xfer_req), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        checkOutput("lap_addr", 32'(bus8.addr),     32'd6);
        checkOutput("lap_ptr",  32'(bus8.ptr),      32'hE);
        checkOutput("lap_xfer", 32'(bus8.xfer_ptr), expXfer(32'd6));
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req",  32'(bus8.xfer_req), 32'd0);
        checkOutput("arst_ptr",  32'(bus8.ptr),      32'd0);
        checkOutput("arst_xfer", 32'(bus8.xfer_ptr), 32'd0);
        checkOutput("arst_busy", 32'(bus8.busy),     32'd0);
        checkOutput("arst_ptr6", 32'(bus6.ptr),      32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("post_rst_req",  32'(bus8.xfer_req), 32'd0);
        checkOutput("post_rst_busy", 32'(bus8.busy),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
